// File: rtl/capture_pkg.sv
// Shared types and constants for the capture sequencer: state encoding,
// UART command bytes, ASCII framing bytes and the nibble-to-hex helper.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARM        = 3'd1,
        ST_CAPTURE    = 3'd2,
        ST_DUMP_FETCH = 3'd3,
        ST_DUMP_SEND  = 3'd4
    } cap_state_t;

    localparam logic [7:0] CMD_S    = 8'h53;
    localparam logic [7:0] CMD_S_LC = 8'h73;
    localparam logic [7:0] CMD_T    = 8'h54;
    localparam logic [7:0] CMD_T_LC = 8'h74;
    localparam logic [7:0] CMD_R    = 8'h52;
    localparam logic [7:0] CMD_R_LC = 8'h72;
    localparam logic [7:0] CMD_A    = 8'h41;
    localparam logic [7:0] CMD_A_LC = 8'h61;

    localparam logic [7:0] LF          = 8'h0A;
    localparam logic [7:0] CR          = 8'h0D;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A_OFS = 8'h37;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        return (n < 4'd10) ? ASCII_0 + {4'd0, n} : ASCII_A_OFS + {4'd0, n};
    endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// Sample stream plus UART RX/TX byte handshakes seen by the capture sequencer.
// The sequencer uses the slave view; the UART/ADC side uses the master view.
interface capture_sequencer_if #(
    parameter int SAMPLE_W = 24
);
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                rx_valid;
    logic                rx_ready;
    logic [7:0]          rx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [7:0]          tx_data;

    modport master (
        output sample_in, sample_valid, rx_valid, rx_data, tx_ready,
        input  rx_ready, tx_valid, tx_data
    );

    modport slave (
        input  sample_in, sample_valid, rx_valid, rx_data, tx_ready,
        output rx_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a
// registered (one-cycle) read.
module capture_ram #(
    parameter int SAMPLE_W = 24,
    parameter int DEPTH    = 4096,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);

    logic [SAMPLE_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; validity is tracked by buf_ok.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/capture_sequencer.sv
// UART-commanded ADC capture controller: immediate or threshold-triggered
// capture into a buffer, then a paced ASCII-hex dump of the buffer over TX.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int                  SAMPLE_W = 24,
    parameter int                  DEPTH    = 4096,
    parameter int                  WAIT_CNT = 5000,
    parameter logic [SAMPLE_W-1:0] THRESH   = 24'h080000
) (
    input  logic                clk,
    input  logic                rst_n,
    capture_sequencer_if.slave  bus,
    output logic                busy,
    output logic [2:0]          state_o,
    output logic                done
);

    localparam int AW   = $clog2(DEPTH);
    localparam int NIBS = SAMPLE_W / 4;
    localparam int NW   = $clog2(NIBS + 2);
    localparam int GW   = $clog2(WAIT_CNT + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [NW-1:0] NIB_LF   = NW'(NIBS);
    localparam logic [NW-1:0] NIB_CR   = NW'(NIBS + 1);

    cap_state_t          state, state_next;
    logic [AW-1:0]       wr_idx, rd_idx, wr_addr;
    logic [NW-1:0]       nib;
    logic [GW-1:0]       gap;
    logic [SAMPLE_W-1:0] prev, shreg, rd_data;
    logic                prev_ok, buf_ok, fetch_wait, abort_pend, tx_valid_q;
    logic [7:0]          tx_data_q, tx_byte;
    logic                wr_en, tx_load, fetch_load, line_next, done_next;
    logic                cmd_s, cmd_t, cmd_r, cmd_a, tx_fire, trig;

    assign cmd_s   = bus.rx_valid && (bus.rx_data == CMD_S || bus.rx_data == CMD_S_LC);
    assign cmd_t   = bus.rx_valid && (bus.rx_data == CMD_T || bus.rx_data == CMD_T_LC);
    assign cmd_r   = bus.rx_valid && (bus.rx_data == CMD_R || bus.rx_data == CMD_R_LC);
    assign cmd_a   = bus.rx_valid && (bus.rx_data == CMD_A || bus.rx_data == CMD_A_LC);
    assign tx_fire = tx_valid_q && bus.tx_ready;
    assign trig    = prev_ok && (prev < THRESH) && (bus.sample_in >= THRESH);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_addr    = wr_idx;
        tx_load    = 1'b0;
        fetch_load = 1'b0;
        line_next  = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_s)                state_next = ST_CAPTURE;
                else if (cmd_t)           state_next = ST_ARM;
                else if (cmd_r && buf_ok) state_next = ST_DUMP_FETCH;
            end
            ST_ARM: begin
                if (cmd_a) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else if (bus.sample_valid && trig) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (cmd_a) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else if (bus.sample_valid) begin
                    wr_en = 1'b1;
                    if (wr_idx == LAST_IDX) state_next = ST_DUMP_FETCH;
                end
            end
            ST_DUMP_FETCH: begin
                if (cmd_a) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else if (fetch_wait) begin
                    fetch_load = 1'b1;
                    state_next = ST_DUMP_SEND;
                end
            end
            ST_DUMP_SEND: begin
                // An abort never cuts a byte that is already on offer.
                if (tx_fire) begin
                    if (cmd_a || abort_pend || (nib == NIB_CR && rd_idx == LAST_IDX)) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else if (nib == NIB_CR) begin
                        line_next  = 1'b1;
                        state_next = ST_DUMP_FETCH;
                    end
                end else if (cmd_a && !tx_valid_q) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else if (!tx_valid_q && gap == '0 && !abort_pend) begin
                    tx_load = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_byte = CR;
        if (nib < NIB_LF)       tx_byte = nib2ascii(shreg[SAMPLE_W-1 -: 4]);
        else if (nib == NIB_LF) tx_byte = LF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx     <= '0;
            rd_idx     <= '0;
            nib        <= '0;
            gap        <= '0;
            prev       <= '0;
            shreg      <= '0;
            prev_ok    <= 1'b0;
            buf_ok     <= 1'b0;
            fetch_wait <= 1'b0;
            abort_pend <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            done       <= 1'b0;
        end else begin
            done       <= done_next;
            fetch_wait <= (state == ST_DUMP_FETCH) && (state_next == ST_DUMP_FETCH);
            abort_pend <= (state_next == ST_DUMP_SEND) && (abort_pend || cmd_a);
            if (gap != '0) gap <= gap - 1'b1;

            if (state == ST_IDLE && state_next == ST_CAPTURE) begin
                wr_idx <= '0;
                buf_ok <= 1'b0;
            end
            if (state == ST_IDLE && state_next == ST_ARM) begin
                prev_ok <= 1'b0;
                buf_ok  <= 1'b0;
            end
            if (state == ST_IDLE && state_next == ST_DUMP_FETCH) rd_idx <= '0;

            if (state == ST_ARM && state_next == ST_ARM && bus.sample_valid) begin
                prev    <= bus.sample_in;
                prev_ok <= 1'b1;
            end
            if (wr_en) wr_idx <= wr_addr + 1'b1;
            if (state == ST_CAPTURE && state_next == ST_DUMP_FETCH) begin
                buf_ok <= 1'b1;
                rd_idx <= '0;
            end

            if (fetch_load) begin
                shreg <= rd_data;
                nib   <= '0;
            end
            if (tx_load) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= tx_byte;
            end
            if (tx_fire) begin
                tx_valid_q <= 1'b0;
                gap        <= GW'(WAIT_CNT - 1);
                nib        <= nib + 1'b1;
                shreg      <= shreg << 4;
            end
            if (line_next) rd_idx <= rd_idx + 1'b1;
        end
    end

    capture_ram #(
        .SAMPLE_W(SAMPLE_W),
        .DEPTH   (DEPTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(bus.sample_in),
        .rd_addr(rd_idx),
        .rd_data(rd_data)
    );

    assign bus.rx_ready = 1'b1;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign busy         = (state != ST_IDLE);
    assign state_o      = state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed/randomized bench for capture_sequencer with a queue-based model of
// the captured buffer and the ASCII dump it should produce.
`timescale 1ns/1ps
module tb_capture_sequencer;

    localparam int          SW       = 24;
    localparam int          DEPTH    = 8;
    localparam int          WAIT_CNT = 4;
    localparam logic [23:0] TH       = 24'h080000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy, done;
    logic [2:0] state_o;

    capture_sequencer_if #(.SAMPLE_W(SW)) bus();

    capture_sequencer #(
        .SAMPLE_W(SW),
        .DEPTH   (DEPTH),
        .WAIT_CNT(WAIT_CNT),
        .THRESH  (TH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .busy   (busy),
        .state_o(state_o),
        .done   (done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          gap_viol = 0;
    int          stable_viol = 0;
    logic [7:0]  byte_q[$];
    logic [7:0]  exp_q[$];
    logic [23:0] drv_q[$];
    logic [23:0] buf_m[$];

    // TX monitor: collects accepted bytes, checks pacing and hold-while-stalled.
    int         low_run = 100;
    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = '0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_run = 100;
            prev_v  = 1'b0;
            prev_r  = 1'b0;
        end else begin
            if (bus.tx_valid && bus.tx_ready) byte_q.push_back(bus.tx_data);
            if (bus.tx_valid && !prev_v && low_run < WAIT_CNT) gap_viol++;
            if (bus.tx_valid && prev_v && !prev_r && bus.tx_data !== prev_d) stable_viol++;
            low_run = bus.tx_valid ? 0 : low_run + 1;
            if (done) done_cnt++;
            prev_v = bus.tx_valid;
            prev_r = bus.tx_ready;
            prev_d = bus.tx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick(1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_sample(input logic [23:0] v);
        bus.sample_valid = 1'b1;
        bus.sample_in    = v;
        tick(1);
        bus.sample_valid = 1'b0;
        drv_q.push_back(v);
        tick(1 + $urandom_range(0, 2));
    endtask

    task automatic wait_done(input int start, input string tag);
        int n = 0;
        while (done_cnt == start && n < 3000) begin
            tick(1);
            n++;
        end
        check({tag, "_done_timeout"}, 32'(n < 3000), 1);
    endtask

    task automatic wait_bytes(input int want, input string tag);
        int n = 0;
        while (byte_q.size() < want && n < 2000) begin
            tick(1);
            n++;
        end
        check({tag, "_bytes_timeout"}, 32'(n < 2000), 1);
    endtask

    task automatic wait_txv(input string tag);
        int n = 0;
        while (!bus.tx_valid && n < 20) begin
            tick(1);
            n++;
        end
        check({tag, "_txv_timeout"}, 32'(n < 20), 1);
    endtask

    // Model: immediate capture keeps the first DEPTH samples after the command.
    function automatic void model_immediate();
        buf_m.delete();
        for (int i = 0; i < DEPTH && i < drv_q.size(); i++) buf_m.push_back(drv_q[i]);
    endfunction

    // Model: triggered capture starts at the first rising crossing; the very
    // first sample only serves as the "previous" value.
    function automatic void model_trigger();
        int start = -1;
        for (int i = 1; i < drv_q.size(); i++)
            if (start < 0 && drv_q[i-1] < TH && drv_q[i] >= TH) start = i;
        buf_m.delete();
        if (start >= 0)
            for (int i = start; i < start + DEPTH && i < drv_q.size(); i++) buf_m.push_back(drv_q[i]);
    endfunction

    function automatic void build_exp();
        exp_q.delete();
        foreach (buf_m[i]) begin
            string s;
            s = $sformatf("%h", buf_m[i]);
            s = s.toupper();
            for (int c = 0; c < s.len(); c++) exp_q.push_back(s[c]);
            exp_q.push_back(8'h0A);
            exp_q.push_back(8'h0D);
        end
    endfunction

    task automatic compare_prefix(input string tag, input int n);
        check({tag, "_len"}, byte_q.size(), n);
        for (int i = 0; i < n && i < byte_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), byte_q[i], exp_q[i]);
    endtask

    int d0, k, idx;

    initial begin
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.rx_valid     = 1'b0;
        bus.rx_data      = '0;
        bus.tx_ready     = 1'b1;

        // Reset state
        #12;
        check("rst_state", state_o, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_txv", bus.tx_valid, 1'b0);
        check("rst_txd", bus.tx_data, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_rxrdy", bus.rx_ready, 1'b1);
        #11 rst_n = 1'b1;
        tick(2);

        // 'R' after reset, 'A' and 'X' in IDLE: all ignored
        d0 = done_cnt;
        send_byte(8'h52);
        tick(2);
        check("r_after_reset", state_o, 3'd0);
        send_byte(8'h41);
        tick(2);
        check("a_in_idle_state", state_o, 3'd0);
        check("a_in_idle_done", done_cnt - d0, 0);
        send_byte(8'h58);
        tick(1);
        check("x_in_idle", state_o, 3'd0);

        // Immediate capture of 0..7, with a stray 's' mid-capture
        drv_q.delete();
        byte_q.delete();
        d0 = done_cnt;
        send_byte(8'h53);
        check("imm_state", state_o, 3'd2);
        check("imm_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) send_sample(24'(i));
        send_byte(8'h73);
        check("imm_s_ignored", state_o, 3'd2);
        for (int i = 3; i < DEPTH; i++) send_sample(24'(i));
        model_immediate();
        build_exp();
        wait_done(d0, "imm");
        compare_prefix("imm", exp_q.size());
        tick(2);
        check("imm_done_pulses", done_cnt - d0, 1);
        check("imm_busy_after", busy, 1'b0);
        check("imm_state_after", state_o, 3'd0);
        check("imm_gap", gap_viol, 0);

        // Triggered capture with backpressure mid-line
        drv_q.delete();
        byte_q.delete();
        d0 = done_cnt;
        send_byte(8'h74);
        check("trg_arm", state_o, 3'd1);
        send_sample(24'h123456);
        send_sample(24'h07FFFF);
        send_sample(24'h07FFFF);
        check("trg_still_arm", state_o, 3'd1);
        send_sample(24'h080000);
        check("trg_fired", state_o, 3'd2);
        send_sample(24'h0ABCDE);
        for (int i = 0; i < DEPTH - 2; i++) send_sample(24'($urandom));
        model_trigger();
        build_exp();
        wait_bytes(11, "bp");
        bus.tx_ready = 1'b0;
        wait_txv("bp");
        idx = byte_q.size();
        tick(20);
        check("bp_txv_held", bus.tx_valid, 1'b1);
        check("bp_txd_held", bus.tx_data, exp_q[idx]);
        check("bp_no_accept", byte_q.size(), idx);
        bus.tx_ready = 1'b1;
        wait_done(d0, "trg");
        compare_prefix("trg", exp_q.size());
        check("trg_stable", stable_viol, 0);
        check("trg_gap", gap_viol, 0);

        // Abort during DUMP_SEND with a byte on offer, then re-send
        byte_q.delete();
        tick(2);
        d0 = done_cnt;
        send_byte(8'h52);
        check("rs_fetch", state_o, 3'd3);
        wait_bytes(10, "ab");
        bus.tx_ready = 1'b0;
        wait_txv("ab");
        k = byte_q.size();
        send_byte(8'h61);
        tick(3);
        check("ab_pending_state", state_o, 3'd4);
        check("ab_pending_txv", bus.tx_valid, 1'b1);
        bus.tx_ready = 1'b1;
        wait_done(d0, "ab");
        compare_prefix("ab", k + 1);
        check("ab_state", state_o, 3'd0);
        tick(2);
        check("ab_done_pulses", done_cnt - d0, 1);
        byte_q.delete();
        d0 = done_cnt;
        send_byte(8'h72);
        wait_done(d0, "resend");
        compare_prefix("resend", exp_q.size());

        // Abort during ARM; buffer is no longer valid so 'R' is ignored
        tick(2);
        d0 = done_cnt;
        send_byte(8'h54);
        check("arm2_state", state_o, 3'd1);
        send_sample(24'($urandom_range(0, 24'h07FFFF)));
        send_byte(8'h41);
        check("arm_abort_state", state_o, 3'd0);
        tick(2);
        check("arm_abort_done", done_cnt - d0, 1);
        send_byte(8'h52);
        tick(2);
        check("r_after_arm_abort", state_o, 3'd0);

        // Asynchronous reset in the middle of a dump
        drv_q.delete();
        byte_q.delete();
        send_byte(8'h53);
        for (int i = 0; i < DEPTH; i++) send_sample(24'($urandom));
        wait_bytes(5, "ar");
        wait_txv("ar");
        #3 rst_n = 1'b0;
        #1;
        check("ar_txv", bus.tx_valid, 1'b0);
        check("ar_busy", busy, 1'b0);
        check("ar_state", state_o, 3'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        send_byte(8'h52);
        tick(2);
        check("ar_r_ignored", state_o, 3'd0);

        // Normal capture after reset release
        drv_q.delete();
        byte_q.delete();
        d0 = done_cnt;
        send_byte(8'h53);
        for (int i = 0; i < DEPTH; i++) send_sample(24'($urandom));
        model_immediate();
        build_exp();
        wait_done(d0, "post");
        compare_prefix("post", exp_q.size());
        check("post_gap", gap_viol, 0);
        check("post_stable", stable_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
